// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM.
// Drives the memory handshakes, decode enable, ALU start, register write and PC update.
// Optional build macro: ILLEGAL_TRAP_EN.
//   When defined, an illegal opcode parks the FSM in TRAP until reset.
//   When undefined, an illegal opcode retires as a NOP.
//
// state | meaning
// ------+----------------------------------------------------------
// FETCH | imem_req held until imem_ready; ir_load in the ready cycle
// DEC0  | dec_en, decode register loading
// DEC1  | dec_en, opcode valid; sampled into op_q
// EXEC  | per-opcode action; MUL/DIV wait here for alu_done
// MEM   | dmem_req (dmem_we for SW) held until dmem_ready
// WB    | rf_we + pc_load(PC+1)
// HALT  | wait limit hit, timeout sticky; reset is the only exit
// TRAP  | illegal opcode (trap build only); reset is the only exit
//
// Wait accounting: the cycle in which a wait starts counts as its first waiting cycle.
// A wait that runs WAIT_LIMIT cycles without ready goes to HALT.
// A ready in the WAIT_LIMIT-th cycle still completes normally.
// branch_taken is sampled in DEC1, together with the opcode.
module instruction_sequencer #(
  parameter int WAIT_W     = 8,
  parameter int WAIT_LIMIT = 200
) (
  input  logic       clock,
  input  logic       reset,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       ir_load,
  output logic       dec_en,
  input  logic [4:0] opcode,
  output logic       alu_start,
  input  logic       alu_done,
  input  logic       branch_taken,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       rf_we,
  output logic       stack_push,
  output logic       stack_pop,
  output logic [1:0] pc_sel,
  output logic       pc_load,
  output logic [2:0] state,
  output logic       timeout
);

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DEC0  = 3'd1,
    S_DEC1  = 3'd2,
    S_EXEC  = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6,
    S_TRAP  = 3'd7
  } state_t;

  localparam logic [4:0] OP_LW   = 5'h00;
  localparam logic [4:0] OP_SW   = 5'h01;
  localparam logic [4:0] OP_MOV  = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_MUL  = 5'h05;
  localparam logic [4:0] OP_DIV  = 5'h06;
  localparam logic [4:0] OP_AND  = 5'h07;
  localparam logic [4:0] OP_OR   = 5'h08;
  localparam logic [4:0] OP_SHL  = 5'h09;
  localparam logic [4:0] OP_SHR  = 5'h0A;
  localparam logic [4:0] OP_CMP  = 5'h0B;
  localparam logic [4:0] OP_NOT  = 5'h0C;
  localparam logic [4:0] OP_JR   = 5'h0D;
  localparam logic [4:0] OP_JPC  = 5'h0E;
  localparam logic [4:0] OP_BRFL = 5'h0F;
  localparam logic [4:0] OP_CALL = 5'h10;
  localparam logic [4:0] OP_RET  = 5'h11;
  localparam logic [4:0] OP_NOP  = 5'h12;

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_LIMIT - 1);

  state_t            state_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [4:0]        op_q;
  logic              pc_load_q;
  logic [1:0]        pc_sel_q;
  logic              wait_last;
  logic              sw_done;

  function automatic logic is_alu(input logic [4:0] op);
    return op inside {OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_NOT};
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_mem(input logic [4:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_illegal(input logic [4:0] op);
    return op > OP_NOP;
  endfunction

  // Opcodes whose single pc_load happens in EXEC.
  function automatic logic retires_in_exec(input logic [4:0] op);
    return (op inside {OP_CMP, OP_JR, OP_JPC, OP_BRFL, OP_CALL, OP_RET, OP_NOP})
           || (is_illegal(op) && !TRAP_EN);
  endfunction

  function automatic logic [1:0] exec_sel(input logic [4:0] op, input logic taken);
    logic [1:0] sel;
    sel = 2'b00;
    case (op)
      OP_JR, OP_CALL: sel = 2'b01;
      OP_JPC:         sel = 2'b10;
      OP_BRFL:        sel = taken ? 2'b10 : 2'b00;
      OP_RET:         sel = 2'b11;
      default:        sel = 2'b00;
    endcase
    return sel;
  endfunction

  assign wait_last = (wait_cnt == LAST_WAIT);
  // The handshake strobes must land in the ready cycle itself, so they are combinational.
  assign ir_load   = imem_req & imem_ready;
  assign sw_done   = (state_q == S_MEM) & dmem_req & dmem_we & dmem_ready;
  assign pc_load   = pc_load_q | sw_done;
  assign pc_sel    = pc_sel_q;
  assign state     = state_q;

  // Sequencer FSM: next state, wait counter and registered strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      wait_cnt   <= '0;
      op_q       <= '0;
      imem_req   <= 1'b0;
      dec_en     <= 1'b0;
      alu_start  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      rf_we      <= 1'b0;
      stack_push <= 1'b0;
      stack_pop  <= 1'b0;
      pc_load_q  <= 1'b0;
      pc_sel_q   <= 2'b00;
      timeout    <= 1'b0;
    end else begin
      alu_start  <= 1'b0;
      rf_we      <= 1'b0;
      stack_push <= 1'b0;
      stack_pop  <= 1'b0;
      pc_load_q  <= 1'b0;
      pc_sel_q   <= 2'b00;
      case (state_q)
        S_FETCH: begin
          if (imem_req && imem_ready) begin
            imem_req <= 1'b0;
            dec_en   <= 1'b1;
            state_q  <= S_DEC0;
          end else if (!imem_req) begin
            // First cycle out of reset: raise the request.
            imem_req <= 1'b1;
            wait_cnt <= '0;
          end else if (wait_last) begin
            imem_req <= 1'b0;
            timeout  <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DEC0: state_q <= S_DEC1;
        S_DEC1: begin
          dec_en     <= 1'b0;
          op_q       <= opcode;
          state_q    <= S_EXEC;
          alu_start  <= is_alu(opcode) || is_muldiv(opcode) || (opcode == OP_CMP);
          stack_push <= (opcode == OP_CALL);
          stack_pop  <= (opcode == OP_RET);
          if (is_muldiv(opcode)) wait_cnt <= '0;
          if (retires_in_exec(opcode)) begin
            pc_load_q <= 1'b1;
            pc_sel_q  <= exec_sel(opcode, branch_taken);
          end
        end
        S_EXEC: begin
          if (is_mem(op_q)) begin
            dmem_req <= 1'b1;
            dmem_we  <= (op_q == OP_SW);
            wait_cnt <= '0;
            state_q  <= S_MEM;
          end else if (is_alu(op_q)) begin
            rf_we     <= 1'b1;
            pc_load_q <= 1'b1;
            state_q   <= S_WB;
          end else if (is_muldiv(op_q)) begin
            if (alu_done) begin
              rf_we     <= 1'b1;
              pc_load_q <= 1'b1;
              state_q   <= S_WB;
            end else if (wait_last) begin
              timeout <= 1'b1;
              state_q <= S_HALT;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else if (is_illegal(op_q) && TRAP_EN) begin
            state_q <= S_TRAP;
          end else begin
            imem_req <= 1'b1;
            wait_cnt <= '0;
            state_q  <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (op_q == OP_SW) begin
              imem_req <= 1'b1;
              wait_cnt <= '0;
              state_q  <= S_FETCH;
            end else begin
              rf_we     <= 1'b1;
              pc_load_q <= 1'b1;
              state_q   <= S_WB;
            end
          end else if (wait_last) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            timeout  <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          imem_req <= 1'b1;
          wait_cnt <= '0;
          state_q  <= S_FETCH;
        end
        S_HALT: state_q <= S_HALT;
        S_TRAP: state_q <= S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed and randomized instructions against a per-instruction
// reference model (expected latency, strobe counts/positions, pc_sel and final state).
module tb_instruction_sequencer;
  localparam int LIMIT  = 200;
  localparam int BUDGET = 700;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       imem_req, imem_ready, ir_load, dec_en, alu_start, alu_done, branch_taken;
  logic       dmem_req, dmem_we, dmem_ready, rf_we, stack_push, stack_pop, pc_load, timeout;
  logic [4:0] opcode;
  logic [1:0] pc_sel;
  logic [2:0] state;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int cycles, fin, tmo;
    int ir_n, ir_at, dec_n, dec_at, alu_n, alu_at, rf_n, rf_at;
    int push_n, pop_n, pcl_n, pcl_at, pcl_sel, dreq_n, dwe_n, stray;
  } res_t;

  instruction_sequencer #(.WAIT_W(8), .WAIT_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_ready(imem_ready),
    .ir_load(ir_load), .dec_en(dec_en), .opcode(opcode), .alu_start(alu_start),
    .alu_done(alu_done), .branch_taken(branch_taken), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ready(dmem_ready), .rf_we(rf_we), .stack_push(stack_push),
    .stack_pop(stack_pop), .pc_sel(pc_sel), .pc_load(pc_load), .state(state),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic res_t blank();
    res_t r;
    r.cycles = 0; r.fin = 0; r.tmo = 0;
    r.ir_n = 0; r.ir_at = -1; r.dec_n = 0; r.dec_at = -1;
    r.alu_n = 0; r.alu_at = -1; r.rf_n = 0; r.rf_at = -1;
    r.push_n = 0; r.pop_n = 0; r.pcl_n = 0; r.pcl_at = -1; r.pcl_sel = 0;
    r.dreq_n = 0; r.dwe_n = 0; r.stray = 0;
    return r;
  endfunction

  // Expected behaviour of one instruction. Cycle 0 is the first FETCH cycle with imem_req.
  // ri/rx/rd: index of the waiting cycle in which imem/alu/dmem ready arrives (>= LIMIT: never).
  function automatic res_t model(int op, int bt, int ri, int rx, int rd);
    res_t r;
    int   e;
    bit   trap_en;
`ifdef ILLEGAL_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    r = blank();
    if (ri >= LIMIT) begin
      r.cycles = LIMIT; r.fin = 6; r.tmo = 1;
      return r;
    end
    r.ir_n = 1; r.ir_at = ri; r.dec_n = 2; r.dec_at = ri + 1;
    e = ri + 3;
    if (op == 0 || op == 1) begin
      r.dreq_n = (rd < LIMIT) ? rd + 1 : LIMIT;
      if (op == 1) r.dwe_n = r.dreq_n;
      if (rd >= LIMIT) begin
        r.cycles = e + 1 + LIMIT; r.fin = 6; r.tmo = 1;
      end else if (op == 0) begin
        r.rf_n = 1; r.rf_at = e + rd + 2; r.pcl_n = 1; r.pcl_at = e + rd + 2; r.cycles = e + rd + 3;
      end else begin
        r.pcl_n = 1; r.pcl_at = e + 1 + rd; r.cycles = e + rd + 2;
      end
    end else if (op inside {2, 3, 4, 7, 8, 9, 10, 12}) begin
      r.alu_n = 1; r.alu_at = e; r.rf_n = 1; r.rf_at = e + 1;
      r.pcl_n = 1; r.pcl_at = e + 1; r.cycles = e + 2;
    end else if (op == 5 || op == 6) begin
      r.alu_n = 1; r.alu_at = e;
      if (rx < LIMIT) begin
        r.rf_n = 1; r.rf_at = e + rx + 1; r.pcl_n = 1; r.pcl_at = e + rx + 1; r.cycles = e + rx + 2;
      end else begin
        r.cycles = e + LIMIT; r.fin = 6; r.tmo = 1;
      end
    end else if (op == 11) begin
      r.alu_n = 1; r.alu_at = e; r.pcl_n = 1; r.pcl_at = e; r.cycles = e + 1;
    end else if (op >= 19 && trap_en) begin
      r.cycles = e + 1; r.fin = 7;
    end else begin
      r.pcl_n = 1; r.pcl_at = e; r.cycles = e + 1;
      case (op)
        13: r.pcl_sel = 1;
        14: r.pcl_sel = 2;
        15: r.pcl_sel = bt ? 2 : 0;
        16: begin r.pcl_sel = 1; r.push_n = 1; end
        17: begin r.pcl_sel = 3; r.pop_n = 1; end
        default: r.pcl_sel = 0;
      endcase
    end
    return r;
  endfunction

  task automatic do_reset();
    logic [15:0] v;
    @(negedge clock);
    reset = 1'b0; imem_ready = 1'b0; alu_done = 1'b0; dmem_ready = 1'b0;
    #1;
    v = {imem_req, ir_load, dec_en, alu_start, dmem_req, dmem_we, rf_we, stack_push,
         stack_pop, pc_sel, pc_load, state, timeout};
    chk("reset.outputs", int'(v), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("reset.first_req", int'(imem_req), 1);
    chk("reset.state", int'(state), 0);
  endtask

  task automatic run_instr(input string tag, input int op, input int bt, input int ri,
                           input int rx, input int rd);
    res_t        ex, ob;
    int          fc, xc, dc, cyc;
    int          st;
    bit          left, done;
    logic [9:0]  sv;
    ex = model(op, bt, ri, rx, rd);
    ob = blank();
    opcode = op[4:0];
    branch_taken = bt[0];
    fc = 0; xc = 0; dc = 0; cyc = 0; left = 1'b0; done = 1'b0;
    while (!done) begin
      st = int'(state);
      if ((st == 0 && left) || st == 6 || st == 7) begin
        done = 1'b1; ob.fin = st;
      end else if (cyc >= BUDGET) begin
        done = 1'b1; ob.fin = -1;
      end else begin
        if (st != 0) left = 1'b1;
        imem_ready = (st == 0) && imem_req && (fc == ri);
        alu_done   = (st == 3) && (op == 5 || op == 6) && (xc == rx);
        dmem_ready = (st == 4) && (dc == rd);
        #1;
        if (ir_load)    begin ob.ir_n++;  if (ob.ir_at < 0)  ob.ir_at = cyc;  end
        if (dec_en)     begin ob.dec_n++; if (ob.dec_at < 0) ob.dec_at = cyc; end
        if (alu_start)  begin ob.alu_n++; if (ob.alu_at < 0) ob.alu_at = cyc; end
        if (rf_we)      begin ob.rf_n++;  if (ob.rf_at < 0)  ob.rf_at = cyc;  end
        if (pc_load) begin
          ob.pcl_n++;
          if (ob.pcl_at < 0) begin ob.pcl_at = cyc; ob.pcl_sel = int'(pc_sel); end
        end else if (pc_sel != 2'b00) begin
          ob.stray++;
        end
        if (stack_push) ob.push_n++;
        if (stack_pop)  ob.pop_n++;
        if (dmem_req)   ob.dreq_n++;
        if (dmem_we)    ob.dwe_n++;
        if (st == 0 && imem_req) fc++;
        if (st == 3) xc++;
        if (st == 4) dc++;
        cyc++;
        @(negedge clock);
        imem_ready = 1'b0; alu_done = 1'b0; dmem_ready = 1'b0;
      end
    end
    ob.cycles = cyc;
    ob.tmo = int'(timeout);
    chk($sformatf("%s.cycles", tag), ob.cycles, ex.cycles);
    chk($sformatf("%s.final_state", tag), ob.fin, ex.fin);
    chk($sformatf("%s.timeout", tag), ob.tmo, ex.tmo);
    chk($sformatf("%s.ir_load_n", tag), ob.ir_n, ex.ir_n);
    chk($sformatf("%s.ir_load_at", tag), ob.ir_at, ex.ir_at);
    chk($sformatf("%s.dec_en_n", tag), ob.dec_n, ex.dec_n);
    chk($sformatf("%s.dec_en_at", tag), ob.dec_at, ex.dec_at);
    chk($sformatf("%s.alu_start_n", tag), ob.alu_n, ex.alu_n);
    chk($sformatf("%s.alu_start_at", tag), ob.alu_at, ex.alu_at);
    chk($sformatf("%s.rf_we_n", tag), ob.rf_n, ex.rf_n);
    chk($sformatf("%s.rf_we_at", tag), ob.rf_at, ex.rf_at);
    chk($sformatf("%s.push_n", tag), ob.push_n, ex.push_n);
    chk($sformatf("%s.pop_n", tag), ob.pop_n, ex.pop_n);
    chk($sformatf("%s.pc_load_n", tag), ob.pcl_n, ex.pcl_n);
    chk($sformatf("%s.pc_load_at", tag), ob.pcl_at, ex.pcl_at);
    chk($sformatf("%s.pc_sel", tag), ob.pcl_sel, ex.pcl_sel);
    chk($sformatf("%s.dmem_req_n", tag), ob.dreq_n, ex.dreq_n);
    chk($sformatf("%s.dmem_we_n", tag), ob.dwe_n, ex.dwe_n);
    chk($sformatf("%s.stray_pc_sel", tag), ob.stray, 0);
    if (ob.fin == 6 || ob.fin == 7) begin
      // HALT/TRAP must ignore every ready and keep all strobes low.
      for (int k = 0; k < 4; k++) begin
        imem_ready = 1'b1; alu_done = 1'b1; dmem_ready = 1'b1;
        #1;
        sv = {imem_req, ir_load, dec_en, alu_start, dmem_req, dmem_we, rf_we,
              stack_push, stack_pop, pc_load};
        chk($sformatf("%s.park_strobes", tag), int'(sv), 0);
        chk($sformatf("%s.park_state", tag), int'(state), ob.fin);
        @(negedge clock);
      end
      imem_ready = 1'b0; alu_done = 1'b0; dmem_ready = 1'b0;
      do_reset();
    end else if (ob.fin != 0) begin
      do_reset();
    end
  endtask

  initial begin
    int op, bt, ri, rx, rd;
    imem_ready = 1'b0; alu_done = 1'b0; dmem_ready = 1'b0;
    opcode = 5'd0; branch_taken = 1'b0;
    repeat (2) @(negedge clock);
    do_reset();

    run_instr("add",        3, 0, 0, 0, 0);
    run_instr("lw",         0, 0, 0, 0, 2);
    run_instr("sw",         1, 0, 1, 0, 1);
    run_instr("brfl_taken", 15, 1, 0, 0, 0);
    run_instr("brfl_not",   15, 0, 2, 0, 0);
    run_instr("cmp",        11, 0, 0, 0, 0);
    run_instr("call",       16, 0, 0, 0, 0);
    run_instr("ret",        17, 0, 0, 0, 0);
    run_instr("jr",         13, 0, 0, 0, 0);
    run_instr("jpc",        14, 0, 0, 0, 0);
    run_instr("nop",        18, 0, 0, 0, 0);
    run_instr("mul",        5, 0, 0, 3, 0);
    run_instr("illegal",    31, 0, 0, 0, 0);
    run_instr("div_edge",   6, 0, 0, LIMIT - 1, 0);
    run_instr("lw_edge",    0, 0, 0, 0, LIMIT - 1);
    run_instr("fetch_edge", 3, 0, LIMIT - 1, 0, 0);
    run_instr("div_tmo",    6, 0, 0, 1000, 0);
    run_instr("fetch_tmo",  3, 0, 1000, 0, 0);

    // Asynchronous reset in the middle of a data access.
    opcode = 5'd0; branch_taken = 1'b0; imem_ready = 1'b1;
    for (int i = 0; i < 20 && state != 3'd4; i++) @(negedge clock);
    imem_ready = 1'b0;
    chk("mem_rst.entered", int'(state), 4);
    repeat (2) @(negedge clock);
    chk("mem_rst.dmem_req_before", int'(dmem_req), 1);
    #2 reset = 1'b0;
    #1;
    chk("mem_rst.dmem_req", int'(dmem_req), 0);
    chk("mem_rst.state", int'(state), 0);
    chk("mem_rst.timeout", int'(timeout), 0);
    do_reset();

    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 31));
      bt = int'($urandom_range(0, 1));
      ri = int'($urandom_range(0, 3));
      rx = int'($urandom_range(0, 6));
      rd = int'($urandom_range(0, 6));
      run_instr($sformatf("rnd%0d_op%0d", n, op), op, bt, ri, rx, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
